// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one block from memory into the cache
// data array, writes the tag on the last word, and stalls the pipe meanwhile.
//   in : clk, rst_n, miss_detected, miss_address,
//        memory_data_valid, memory_data
//   out: fsm_busy, mem_en, memory_address, write_data_array,
//        fill_word, fill_data, write_tag_array, fill_base
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  output logic                           fsm_busy,
  output logic                           mem_en,
  output logic [ADDR_W-1:0]              memory_address,
  input  logic                           memory_data_valid,
  input  logic [DATA_W-1:0]              memory_data,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           write_tag_array,
  output logic [ADDR_W-1:0]              fill_base
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = WW + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     issue_cnt;
  logic [WW-1:0]     recv_cnt;
  logic [ADDR_W-1:0] base_reg;
  logic              issuing;
  logic              recv;
  logic              last;
  logic [WW-1:0]     off_word;
  logic [ADDR_W-1:0] off_byte;

  // BLOCK_WORDS is a power of two, so the counter MSB marks "all issued".
  assign issuing = ~issue_cnt[CW-1];
  assign recv    = (state == FILL) && memory_data_valid;
  assign last    = (recv_cnt == {WW{1'b1}});

  // After the last request the address sticks on the final word.
  assign off_word = issuing ? issue_cnt[WW-1:0] : {WW{1'b1}};
  assign off_byte = {{(ADDR_W-WW-1){1'b0}}, off_word, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    fill_base        = base_reg;
    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        mem_en           = issuing;
        memory_address   = base_reg + off_byte;
        fill_word        = recv_cnt;
        write_data_array = memory_data_valid;
        write_tag_array  = memory_data_valid && last;
        if (memory_data_valid) begin
          fill_data = memory_data;
        end
        if (recv && last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base_reg  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_detected) begin
            base_reg  <= miss_address & ~OFF_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized and directed bench for cache_fill_fsm against a
// cycle-level reference model plus per-fill timing/address checks.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_base;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_base         (fill_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } req_t;

  req_t        rq[$];
  logic [15:0] addr_log[$];
  logic [15:0] wd_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 4;
  logic [15:0] key = 16'hA000;
  int          busy_len;
  int          tag_cnt;
  int          tag_idx;

  // reference: fill in progress, its base, requests sent, words received
  bit          m_busy;
  logic [15:0] m_base;
  int          m_iss;
  int          m_rcv;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic miss, input logic [15:0] maddr,
                       input logic spur);
    logic        mv;
    logic [15:0] md;
    logic        e_en;
    logic        e_wr;
    mv = 1'b0;
    md = 16'($urandom);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mv = 1'b1;
      md = key + {13'd0, rq[0].addr[3:1]};
      void'(rq.pop_front());
    end
    if (spur) mv = 1'b1;
    miss_detected     = miss;
    miss_address      = maddr;
    memory_data_valid = mv;
    memory_data       = md;
    #1;
    e_en = m_busy && (m_iss < 8);
    e_wr = m_busy && mv;
    chk("busy", fsm_busy, m_busy);
    chk("mem_en", mem_en, e_en);
    chk("wr_data", write_data_array, e_wr);
    chk("wr_tag", write_tag_array, e_wr && (m_rcv == 7));
    chk("fill_base", fill_base, m_base);
    if (e_en) chk("mem_addr", memory_address, m_base + 16'(2 * m_iss));
    if (e_wr) begin
      chk("fill_word", fill_word, m_rcv[2:0]);
      chk("fill_data", fill_data, md);
    end
    if (!m_busy) chk("idle_word", fill_word, 0);
    if (mem_en) rq.push_back('{cyc + lat, memory_address});
    if (fsm_busy) busy_len++;
    if (mem_en) addr_log.push_back(memory_address);
    if (write_data_array) wd_log.push_back(fill_data);
    if (write_tag_array) begin
      tag_cnt++;
      tag_idx = int'(fill_word);
    end
    if (!m_busy) begin
      if (miss) begin
        m_busy = 1'b1;
        m_base = maddr & 16'hFFF0;
        m_iss  = 0;
        m_rcv  = 0;
      end
    end else begin
      if (m_iss < 8) m_iss++;
      if (mv) begin
        if (m_rcv == 7) m_busy = 1'b0;
        m_rcv++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_fill(input logic [15:0] addr, input int l,
                          input logic hold, input logic [15:0] alt,
                          input logic [15:0] k);
    logic [15:0] base;
    int          n;
    lat      = l;
    key      = k;
    base     = addr & 16'hFFF0;
    busy_len = 0;
    tag_cnt  = 0;
    tag_idx  = -1;
    addr_log.delete();
    wd_log.delete();
    cycle(1'b1, addr, 1'b0);
    n = 0;
    while (m_busy && n < 40) begin
      cycle(hold, (n > 3) ? alt : addr, 1'b0);
      n++;
    end
    if (n >= 40) chk("fill_timeout", 1, 0);
    chk("busy_len", busy_len, 8 + l);
    chk("req_cnt", addr_log.size(), 8);
    chk("wr_cnt", wd_log.size(), 8);
    for (int i = 0; i < addr_log.size() && i < 8; i++)
      chk("req_addr", addr_log[i], base + 16'(2 * i));
    for (int i = 0; i < wd_log.size() && i < 8; i++)
      chk("wr_seq", wd_log[i], k + 16'(i));
    chk("tag_cnt", tag_cnt, 1);
    chk("tag_idx", tag_idx, 7);
    chk("base_out", fill_base, base);
  endtask

  task automatic idle_gap(input int n, input logic spur);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), spur);
  endtask

  initial begin
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    m_busy = 1'b0;
    m_base = '0;
    m_iss  = 0;
    m_rcv  = 0;
    #3;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_wr", write_data_array, 0);
    chk("rst_tag", write_tag_array, 0);
    chk("rst_base", fill_base, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_gap(2, 1'b0);

    run_fill(16'h1236, 4, 1'b0, 16'h1236, 16'hA000);
    idle_gap(2, 1'b0);
    run_fill(16'h1236, 1, 1'b0, 16'h1236, 16'hA000);
    idle_gap(1, 1'b0);
    run_fill(16'h1236, 6, 1'b0, 16'h1236, 16'hA000);
    idle_gap(2, 1'b0);

    // requester holds the miss and retargets it mid-fill
    run_fill(16'h0040, 3, 1'b1, 16'h8000, 16'h3100);
    run_fill(16'h8000, 3, 1'b0, 16'h8000, 16'h4200);
    idle_gap(2, 1'b0);

    // spurious returns while idle
    idle_gap(4, 1'b1);

    // reset after the third return of a fill
    lat = 4;
    key = 16'h5500;
    cycle(1'b1, 16'h2468, 1'b0);
    for (int i = 0; i < 40 && m_rcv < 3; i++)
      cycle(1'b1, 16'h2468, 1'b0);
    miss_detected = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", fsm_busy, 0);
    chk("arst_en", mem_en, 0);
    chk("arst_addr", memory_address, 0);
    chk("arst_wr", write_data_array, 0);
    chk("arst_tag", write_tag_array, 0);
    chk("arst_word", fill_word, 0);
    chk("arst_data", fill_data, 0);
    chk("arst_base", fill_base, 0);
    m_busy = 1'b0;
    m_base = '0;
    #1;
    rst_n = 1'b1;
    idle_gap(5, 1'b1);
    rq.delete();
    run_fill(16'h0100, 2, 1'b0, 16'h0100, 16'h6600);
    idle_gap(1, 1'b0);

    run_fill(16'hFFFA, 5, 1'b0, 16'hFFFA, 16'h7700);
    idle_gap(1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_fill(16'($urandom), $urandom_range(1, 6),
               1'($urandom), 16'($urandom), 16'($urandom));
      idle_gap($urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
